// File: rtl/tt_gpio_cfg_ctrl.sv
// Runtime pad configuration controller: shadow/active banks with a staggered, one-pad-at-a-time commit.
// Optional readback port enabled by defining TT_GPIO_CFG_READBACK_EN.
module tt_gpio_cfg_ctrl #(
    parameter int                      N_PADS         = 44,
    parameter int                      CFG_W          = 16,
    parameter int                      AW             = 6,
    parameter int                      STAGGER        = 2,
    parameter logic [N_PADS*CFG_W-1:0] DEFAULT_CONFIG = {N_PADS{16'h0001}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [AW-1:0]             wr_addr,
    input  logic [CFG_W-1:0]          wr_data,
    output logic                      wr_err,
    input  logic                      commit,
    input  logic                      lock,
    output logic                      locked,
    output logic                      busy,
    output logic                      done,
    output logic [N_PADS*CFG_W-1:0]   cfg_out
`ifdef TT_GPIO_CFG_READBACK_EN
    ,
    input  logic [AW-1:0]             rd_addr,
    output logic [CFG_W:0]            rd_data
`endif
);

    localparam int              IW        = (N_PADS > 1) ? $clog2(N_PADS) : 1;
    localparam int              SW        = (STAGGER > 0) ? $clog2(STAGGER + 1) : 1;
    localparam logic [AW:0]     N_PADS_A  = (AW+1)'(N_PADS);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(N_PADS - 1);
    localparam logic [SW-1:0]   STAGGER_C = SW'(STAGGER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                wr_err_q;
    logic                locked_q;

    logic [CFG_W-1:0]    shadow_q [N_PADS];
    logic [CFG_W-1:0]    active_q [N_PADS];
    logic [N_PADS-1:0]   dirty_q;

    logic wr_fire;
    logic wr_in_range;
    logic wr_set;
    logic cur_dirty;
    logic apply_upd;
    logic last_pad;

    assign wr_ready    = (state_q == IDLE) & ~locked_q;
    assign wr_fire     = wr_valid & wr_ready;
    assign wr_in_range = ({1'b0, wr_addr} < N_PADS_A);
    assign wr_set      = wr_fire & wr_in_range;
    assign cur_dirty   = dirty_q[idx_q];
    assign apply_upd   = (state_q == APPLY) & cur_dirty;
    assign last_pad    = (idx_q == LAST_IDX);

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign wr_err = wr_err_q;
    assign locked = locked_q;

    // Per-pad storage; only the pad under the apply pointer can move shadow -> active.
    generate
        for (genvar gi = 0; gi < N_PADS; gi++) begin : g_pad
            logic wr_hit;
            logic ap_hit;

            assign wr_hit = wr_set & (wr_addr == AW'(gi));
            assign ap_hit = apply_upd & (idx_q == IW'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q[gi] <= DEFAULT_CONFIG[CFG_W*gi +: CFG_W];
                    active_q[gi] <= DEFAULT_CONFIG[CFG_W*gi +: CFG_W];
                    dirty_q[gi]  <= 1'b0;
                end else begin
                    if (wr_hit) begin
                        shadow_q[gi] <= wr_data;
                    end
                    if (ap_hit) begin
                        active_q[gi] <= shadow_q[gi];
                    end
                    if (wr_hit) begin
                        dirty_q[gi] <= 1'b1;
                    end else if (ap_hit) begin
                        dirty_q[gi] <= 1'b0;
                    end
                end
            end

            assign cfg_out[CFG_W*gi +: CFG_W] = active_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    // A write landing in the same cycle counts as dirty for this commit.
                    if ((dirty_q != '0) || wr_set) begin
                        state_d = APPLY;
                        idx_d   = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            APPLY: begin
                if (cur_dirty && (STAGGER > 0)) begin
                    state_d = WAIT;
                    cnt_d   = STAGGER_C;
                end else if (last_pad) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q <= SW'(1)) begin
                    if (last_pad) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = APPLY;
                        idx_d   = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            wr_err_q <= wr_fire & ~wr_in_range;
            if (lock) begin
                locked_q <= 1'b1;
            end
        end
    end

`ifdef TT_GPIO_CFG_READBACK_EN
    logic [CFG_W:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if ({1'b0, rd_addr} < N_PADS_A) begin
            rd_data_q <= {dirty_q[rd_addr], shadow_q[rd_addr]};
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_tt_gpio_cfg_ctrl.sv
// Self-checking bench for tt_gpio_cfg_ctrl: directed scenarios plus randomized writes/commits
// checked cycle by cycle against a schedule-based reference model.
module tb_tt_gpio_cfg_ctrl;

    localparam int N  = 44;
    localparam int W  = 16;
    localparam int AW = 6;
    localparam int S  = 2;
    localparam logic [N*W-1:0] DEF = {N{16'h0001}};

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_valid;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [W-1:0]   wr_data;
    logic           wr_err;
    logic           commit;
    logic           lock;
    logic           locked;
    logic           busy;
    logic           done;
    logic [N*W-1:0] cfg_out;
`ifdef TT_GPIO_CFG_READBACK_EN
    logic [AW-1:0]  rd_addr;
    logic [W:0]     rd_data;
`endif

    tt_gpio_cfg_ctrl #(
        .N_PADS(N), .CFG_W(W), .AW(AW), .STAGGER(S), .DEFAULT_CONFIG(DEF)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(wr_err), .commit(commit), .lock(lock), .locked(locked),
        .busy(busy), .done(done), .cfg_out(cfg_out)
`ifdef TT_GPIO_CFG_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sh_m  [N];
    logic [W-1:0] act_m [N];
    bit           dr_m  [N];
    bit           lk_m;

    function automatic logic [N*W-1:0] exp_cfg();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[W*i +: W] = act_m[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_m[i]  = 16'h0001;
            act_m[i] = 16'h0001;
            dr_m[i]  = 1'b0;
        end
        lk_m = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; commit = 1'b0; lock = 1'b0;
        wr_addr = '0; wr_data = '0;
`ifdef TT_GPIO_CFG_READBACK_EN
        rd_addr = '0;
`endif
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        $display("reset");
        checks++; if (cfg_out !== DEF) begin errors++; $display("FAIL reset_cfg got %h exp %h", cfg_out, DEF); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
        checks++; if (done !== 1'b0 || wr_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b wr_err=%b exp 0/0", done, wr_err); end
`ifdef TT_GPIO_CFG_READBACK_EN
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
`endif
    endtask

    // Single write from IDLE; acceptance follows the lock state only.
    task automatic do_write(input int a, input logic [W-1:0] d);
        bit acc;
        acc = !lk_m;
        checks++; if (wr_ready !== acc) begin errors++; $display("FAIL wr_ready got %b exp %b", wr_ready, acc); end
        wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
        tick();
        wr_valid = 1'b0;
        if (acc && a < N) begin
            sh_m[a] = d;
            dr_m[a] = 1'b1;
        end
        $display("write addr=%0d data=%h accepted=%0d", a, d, acc);
        checks++; if (wr_err !== (acc && a >= N)) begin errors++; $display("FAIL wr_err got %b exp %b", wr_err, (acc && a >= N)); end
        checks++; if (cfg_out !== exp_cfg()) begin errors++; $display("FAIL wr_cfg got %h exp %h", cfg_out, exp_cfg()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy got %b exp 0", busy); end
    endtask

    // Commit, optionally with a same-cycle write, then track the whole apply cycle by cycle.
    task automatic commit_run(input bit with_wr, input int wa, input logic [W-1:0] wd,
                              input int lock_at, input int rst_at, input bit noise);
        int  e [N];
        int  k;
        int  done_off;
        bit  bexp;
        bit  lock_drv;
        commit = 1'b1;
        if (with_wr) begin
            wr_valid = 1'b1; wr_addr = AW'(wa); wr_data = wd;
        end
        tick();
        commit = 1'b0; wr_valid = 1'b0;
        if (with_wr && !lk_m && wa < N) begin
            sh_m[wa] = wd;
            dr_m[wa] = 1'b1;
        end
        k = 0;
        for (int i = 0; i < N; i++) begin
            e[i] = i + 1 + k * S;
            if (dr_m[i]) k++;
        end
        done_off = (k > 0) ? (N + k * S) : 0;
        $display("commit dirty=%0d done_at=+%0d", k, done_off);
        for (int o = 0; o <= done_off + 1; o++) begin
            for (int i = 0; i < N; i++) begin
                if (dr_m[i] && e[i] == o) begin
                    act_m[i] = sh_m[i];
                    dr_m[i]  = 1'b0;
                end
            end
            bexp = (k > 0) && (o < done_off);
            checks++; if (cfg_out !== exp_cfg()) begin errors++; $display("FAIL apply_cfg +%0d got %h exp %h", o, cfg_out, exp_cfg()); end
            checks++; if (busy !== bexp) begin errors++; $display("FAIL apply_busy +%0d got %b exp %b", o, busy, bexp); end
            checks++; if (done !== (o == done_off)) begin errors++; $display("FAIL apply_done +%0d got %b exp %b", o, done, (o == done_off)); end
            checks++; if (wr_ready !== (!bexp && !lk_m)) begin errors++; $display("FAIL apply_wr_ready +%0d got %b exp %b", o, wr_ready, (!bexp && !lk_m)); end
            checks++; if (locked !== lk_m || wr_err !== 1'b0) begin errors++; $display("FAIL apply_flags +%0d got locked=%b wr_err=%b exp %b/0", o, locked, wr_err, lk_m); end
            if (o == rst_at) begin
                rst = 1'b1; commit = 1'b0; wr_valid = 1'b0; lock = 1'b0;
                tick();
                rst = 1'b0;
                model_reset();
                $display("reset mid-apply at +%0d", o);
                checks++; if (cfg_out !== DEF) begin errors++; $display("FAIL abort_cfg got %h exp %h", cfg_out, DEF); end
                checks++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin errors++; $display("FAIL abort_state got busy=%b wr_ready=%b exp 0/1", busy, wr_ready); end
                return;
            end
            commit   = noise && bexp && ($urandom_range(0, 2) == 0);
            wr_valid = noise && bexp && ($urandom_range(0, 1) == 0);
            wr_addr  = AW'($urandom_range(0, N - 1));
            wr_data  = W'($urandom);
            lock_drv = (o == lock_at);
            lock     = lock_drv;
            tick();
            if (lock_drv) lk_m = 1'b1;
        end
        commit = 1'b0; wr_valid = 1'b0; lock = 1'b0;
    endtask

    task automatic test_two_pads();
        do_write(5, 16'h6006);
        do_write(20, 16'h4006);
        commit_run(1'b0, 0, '0, -1, -1, 1'b0);
    endtask

    task automatic test_bad_addr();
        do_write(50, 16'h1234);
        commit_run(1'b0, 0, '0, -1, -1, 1'b0);
    endtask

    task automatic test_same_cycle_commit();
        commit_run(1'b1, 0, 16'h0400, -1, -1, 1'b1);
    endtask

    task automatic test_lock();
        do_write(7, 16'h2A2A);
        do_write(43, 16'h5A5A);
        commit_run(1'b0, 0, '0, 10, -1, 1'b0);
        do_write(3, 16'hBEEF);
        commit_run(1'b0, 0, '0, -1, -1, 1'b0);
        test_reset();
    endtask

    task automatic test_reset_mid_apply();
        do_write(5, 16'h6006);
        do_write(30, 16'h7777);
`ifdef TT_GPIO_CFG_READBACK_EN
        rd_addr = AW'(5);
        tick();
        checks++; if (rd_data !== {1'b1, 16'h6006}) begin errors++; $display("FAIL readback got %h exp %h", rd_data, {1'b1, 16'h6006}); end
        rd_addr = AW'(50);
        tick();
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL readback_oob got %h exp 0", rd_data); end
`endif
        commit_run(1'b0, 0, '0, -1, 7, 1'b0);
        commit_run(1'b0, 0, '0, -1, -1, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int nw;
            nw = $urandom_range(1, 6);
            for (int j = 0; j < nw; j++) begin
                do_write($urandom_range(0, 49), W'($urandom));
            end
            if (r == 1) do_write(N - 1, W'($urandom));
            if (r == 2) do_write(0, W'($urandom));
            commit_run(1'b0, 0, '0, -1, -1, 1'b1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_two_pads();
        test_bad_addr();
        test_same_cycle_commit();
        test_lock();
        test_reset_mid_apply();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
